// File: rtl/ibex_rvfi_trace_fifo.sv
// rtl/ibex_rvfi_trace_fifo.sv - RVFI retirement trace packer and FIFO with overflow and order checks
// Optional drop counter: define IBEX_RVFI_TRACE_DROP_CNT_EN.
module ibex_rvfi_trace_fifo #(
    parameter int unsigned Depth  = 8,
    parameter int unsigned TraceW = 376,
    parameter int unsigned LvlW   = $clog2(Depth) + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              enable_i,
    input  logic              clear_i,
    input  logic              rvfi_valid_i,
    input  logic [63:0]       rvfi_order_i,
    input  logic [31:0]       rvfi_insn_i,
    input  logic              rvfi_trap_i,
    input  logic              rvfi_halt_i,
    input  logic              rvfi_intr_i,
    input  logic [4:0]        rvfi_rd_addr_i,
    input  logic [31:0]       rvfi_rd_wdata_i,
    input  logic [31:0]       rvfi_pc_rdata_i,
    input  logic [31:0]       rvfi_pc_wdata_i,
    input  logic [31:0]       rvfi_mem_addr_i,
    input  logic [7:0]        rvfi_mem_rmask_i,
    input  logic [7:0]        rvfi_mem_wmask_i,
    input  logic [63:0]       rvfi_mem_rdata_i,
    input  logic [63:0]       rvfi_mem_wdata_i,
    output logic              trace_valid_o,
    input  logic              trace_ready_i,
    output logic [TraceW-1:0] trace_data_o,
    output logic [LvlW-1:0]   level_o,
`ifdef IBEX_RVFI_TRACE_DROP_CNT_EN
    output logic [15:0]       drop_cnt_o,
`endif
    output logic              overflow_o,
    output logic              order_err_o
);

    localparam int unsigned AW = $clog2(Depth);

    logic [TraceW-1:0] mem_q [Depth];
    logic [LvlW-1:0]   wptr_q;
    logic [LvlW-1:0]   rptr_q;
    logic [LvlW-1:0]   level;
    logic [TraceW-1:0] record;
    logic              push_req;
    logic              pop;
    logic              full;
    logic              do_push;
    logic              drop;
    logic              first_seen_q;
    logic [63:0]       last_order_q;
    logic              order_err_q;

    assign record = {rvfi_order_i, rvfi_insn_i, rvfi_pc_rdata_i, rvfi_pc_wdata_i,
                     rvfi_rd_wdata_i, rvfi_mem_addr_i, rvfi_mem_rmask_i, rvfi_mem_wmask_i,
                     rvfi_mem_rdata_i, rvfi_mem_wdata_i, rvfi_rd_addr_i,
                     rvfi_trap_i, rvfi_halt_i, rvfi_intr_i};

    // Extra pointer MSB distinguishes full from empty, so the difference is the level.
    assign level    = wptr_q - rptr_q;
    assign full     = (level == LvlW'(Depth));
    assign push_req = rvfi_valid_i && enable_i && !clear_i;
    assign pop      = trace_valid_o && trace_ready_i && !clear_i;
    assign do_push  = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    assign trace_valid_o = (level != '0);
    assign level_o       = level;
    assign trace_data_o  = mem_q[rptr_q[AW-1:0]];
    assign order_err_o   = order_err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= record;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (clear_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + LvlW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + LvlW'(1);
            end
        end
    end

    // Continuity is checked on every capture attempt, including records about to be dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            first_seen_q <= 1'b0;
            last_order_q <= '0;
            order_err_q  <= 1'b0;
        end else if (clear_i) begin
            first_seen_q <= 1'b0;
            order_err_q  <= 1'b0;
        end else if (!enable_i) begin
            first_seen_q <= 1'b0;
        end else if (rvfi_valid_i) begin
            if (first_seen_q && (rvfi_order_i != last_order_q + 64'd1)) begin
                order_err_q <= 1'b1;
            end
            last_order_q <= rvfi_order_i;
            first_seen_q <= 1'b1;
        end
    end

`ifdef IBEX_RVFI_TRACE_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt_q <= '0;
        end else if (clear_i) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
    assign overflow_o = (drop_cnt_q != 16'd0);
`else
    logic overflow_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_q <= 1'b0;
        end else if (clear_i) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow_o = overflow_q;
`endif

endmodule

// File: doc/ibex_rvfi_trace_fifo.md
Name: ibex_rvfi_trace_fifo

Overview:
- Sits directly downstream of the TestRIG Ibex top wrapper and consumes its RVFI retirement outputs.
- Packs each retired instruction into one fixed-width trace record and buffers it in a FIFO.
- Presents records on a valid/ready stream to the TestRIG trace serialiser.
- The core cannot be stalled, so records arriving while the FIFO is full are dropped and flagged. The block also checks retirement-order continuity.

Parameters:
- Depth, 8, FIFO entries; power of two, ≥2.
- TraceW, 376, record width; fixed, not overridable in practice.
- LvlW, $clog2(Depth)+1, width of level_o.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- enable_i  in  1  capture enable
- clear_i  in  1  sync flush of FIFO and sticky flags
- rvfi_valid_i  in  1  retirement strobe
- rvfi_order_i  in  64  retirement index
- rvfi_insn_i  in  32  instruction
- rvfi_trap_i / rvfi_halt_i / rvfi_intr_i  in  1 each  status bits
- rvfi_rd_addr_i  in  5  destination register
- rvfi_rd_wdata_i / rvfi_pc_rdata_i / rvfi_pc_wdata_i / rvfi_mem_addr_i  in  32 each  RVFI fields
- rvfi_mem_rmask_i / rvfi_mem_wmask_i  in  8 each  byte masks
- rvfi_mem_rdata_i / rvfi_mem_wdata_i  in  64 each  memory data
- trace_valid_o  out  1  head record valid
- trace_ready_i  in  1  consumer accepts
- trace_data_o  out  TraceW  head record
- level_o  out  LvlW  occupied entries
- overflow_o  out  1  sticky: ≥1 record dropped
- order_err_o  out  1  sticky: order discontinuity

Behaviour:
- Reset values:
  - trace_valid_o=0, level_o=0, overflow_o=0, order_err_o=0.
  - trace_data_o=0 (it reads the empty head slot; storage is reset to 0).
  - Internal first_seen=0, last_order=0.
- Record layout, MSB→LSB:
  - order[63:0], insn[31:0], pc_rdata, pc_wdata, rd_wdata, mem_addr (32 each).
  - mem_rmask[7:0], mem_wmask[7:0], mem_rdata[63:0], mem_wdata[63:0].
  - rd_addr[4:0], trap, halt, intr.
  - Total 376 bits.
- Push: rvfi_valid_i && enable_i && !clear_i.
  - Written at clk edge. Record visible on trace_data_o with trace_valid_o=1 the next cycle if the FIFO was empty (1-cycle latency, no combinational bypass).
- Pop: trace_valid_o && trace_ready_i. Head advances at the edge.
  - trace_data_o is stable while valid && !ready.
- trace_valid_o = (level != 0).
- Full: push while level==Depth and no pop in the same cycle → record dropped, overflow_o set, level unchanged.
  - Push and pop in the same cycle while full → push accepted, level stays Depth.
- Empty: pop is impossible (trace_valid_o=0). Push and pop in the same cycle at level 1 → level stays 1.
- Pointers: wrap modulo Depth. level_o = wptr - rptr using LvlW-bit pointers, so full and empty are distinguished by the MSB.
- Order check, on every push attempt including dropped records:
  - If first_seen && order != last_order+1 (64-bit wrap), set order_err_o.
  - Then last_order←order and first_seen←1.
- enable_i=0: retirements ignored. No order check and no overflow. first_seen is cleared so checking restarts on re-enable.
- clear_i=1, which has priority over push/pop:
  - Pointers reset, level 0.
  - overflow_o, order_err_o and first_seen cleared.
  - A concurrent rvfi_valid_i is discarded without flagging.
- Reset mid-operation: all state returns to reset values asynchronously; no partial record is emitted.

Optional Feature:
- Macro: IBEX_RVFI_TRACE_DROP_CNT_EN.
- With the macro defined:
  - Adds output drop_cnt_o [15:0].
  - Increments by 1 on each dropped record and saturates at 16'hFFFF.
  - Cleared by reset and clear_i.
  - overflow_o = (drop_cnt_o != 0).
- Without the macro: the port and counter are absent, and overflow_o is the sticky flag described above.

Test Plan:
- Single retirement, order=5, insn=32'h00000013, ready=1 → trace_valid_o high the next cycle, trace_data_o[375:312]=5, popped the following cycle, level_o returns to 0.
- Depth=8, ready=0, 10 consecutive retirements (orders 0..9) → level_o=8, overflow_o=1, outputs orders 0..7 in sequence once ready=1. Option built: drop_cnt_o=2.
- Full FIFO, ready=1 and push in the same cycle → no drop, level_o stays 8, overflow_o stays 0.
- Orders 10, 11, 13 → order_err_o set on the cycle after order 13; orders 14, 15 leave it set; clear_i pulse → 0.
- clear_i asserted together with rvfi_valid_i at level 3 → level_o=0, trace_valid_o=0, no flags set.
- Assert rst_ni low with level 4 and both flags set → all outputs return to reset values immediately, before the next clk edge.
